// File: rtl/token_nest_checker_if.sv
// Character stream in, nesting status out, for token_nest_checker.
interface token_nest_checker_if #(
  parameter int unsigned DEPTH_W = 8
);
  logic [7:0]         in;
  logic               in_valid;
  logic               result;
  logic [DEPTH_W-1:0] depth;
  logic               err_uf;
  logic               err_ovf;

  modport master (
    output in, in_valid,
    input  result, depth, err_uf, err_ovf
  );

  modport slave (
    input  in, in_valid,
    output result, depth, err_uf, err_ovf
  );
endinterface

// File: rtl/token_nest_checker.sv
// Tracks begin/end keyword nesting in a space-delimited ASCII stream.
// A keyword's depth change is applied when its last letter arrives and is undone if the word continues.
module token_nest_checker #(
  parameter int unsigned DEPTH_W   = 8,
  parameter int unsigned STICKY_UF = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  token_nest_checker_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_B,
    S_BE,
    S_BEG,
    S_BEGI,
    S_BPEND,
    S_E,
    S_EN,
    S_EPEND,
    S_SKIP,
    S_DEAD
  } state_t;

  localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;
  localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);

  state_t             r_state, w_state;
  logic [DEPTH_W-1:0] r_depth, w_depth;
  logic               r_err_uf, w_err_uf;
  logic               r_err_ovf, w_err_ovf;
  logic               r_ovf_p, w_ovf_p;
  logic               r_uf_p, w_uf_p;
  logic [7:0]         w_ch;
  logic               w_sp;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_depth   <= '0;
      r_err_uf  <= 1'b0;
      r_err_ovf <= 1'b0;
      r_ovf_p   <= 1'b0;
      r_uf_p    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_depth   <= w_depth;
      r_err_uf  <= w_err_uf;
      r_err_ovf <= w_err_ovf;
      r_ovf_p   <= w_ovf_p;
      r_uf_p    <= w_uf_p;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_depth   = r_depth;
    w_err_uf  = r_err_uf;
    w_err_ovf = r_err_ovf;
    w_ovf_p   = r_ovf_p;
    w_uf_p    = r_uf_p;
    w_ch      = to_lower(bus.in);
    w_sp      = (bus.in == 8'h20);

    if (bus.in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_sp)                w_state = S_IDLE;
          else if (w_ch == 8'h62)  w_state = S_B;
          else if (w_ch == 8'h65)  w_state = S_E;
          else                     w_state = S_SKIP;
        end
        S_B: begin
          if (w_sp)                w_state = S_IDLE;
          else if (w_ch == 8'h65)  w_state = S_BE;
          else                     w_state = S_SKIP;
        end
        S_BE: begin
          if (w_sp)                w_state = S_IDLE;
          else if (w_ch == 8'h67)  w_state = S_BEG;
          else                     w_state = S_SKIP;
        end
        S_BEG: begin
          if (w_sp)                w_state = S_IDLE;
          else if (w_ch == 8'h69)  w_state = S_BEGI;
          else                     w_state = S_SKIP;
        end
        S_BEGI: begin
          if (w_sp) begin
            w_state = S_IDLE;
          end else if (w_ch == 8'h6E) begin
            w_state = S_BPEND;
            if (r_depth == MAX_DEPTH) w_ovf_p = 1'b1;
            else                      w_depth = r_depth + ONE;
          end else begin
            w_state = S_SKIP;
          end
        end
        S_E: begin
          if (w_sp)                w_state = S_IDLE;
          else if (w_ch == 8'h6E)  w_state = S_EN;
          else                     w_state = S_SKIP;
        end
        S_EN: begin
          if (w_sp) begin
            w_state = S_IDLE;
          end else if (w_ch == 8'h64) begin
            w_state = S_EPEND;
            if (r_depth == '0) w_uf_p  = 1'b1;
            else               w_depth = r_depth - ONE;
          end else begin
            w_state = S_SKIP;
          end
        end
        S_BPEND: begin
          w_ovf_p = 1'b0;
          if (w_sp) begin
            w_state = S_IDLE;
            if (r_ovf_p) w_err_ovf = 1'b1;
          end else begin
            // Saturated begin never moved depth, so there is nothing to undo.
            w_state = S_SKIP;
            if (!r_ovf_p) w_depth = r_depth - ONE;
          end
        end
        S_EPEND: begin
          w_uf_p = 1'b0;
          if (w_sp) begin
            w_state = S_IDLE;
            if (r_uf_p) begin
              w_err_uf = 1'b1;
              if (STICKY_UF != 0) w_state = S_DEAD;
            end
          end else begin
            w_state = S_SKIP;
            if (!r_uf_p) w_depth = r_depth + ONE;
          end
        end
        S_SKIP: begin
          if (w_sp) w_state = S_IDLE;
        end
        S_DEAD: begin
          w_state = S_DEAD;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  assign bus.depth   = r_depth;
  assign bus.err_uf  = r_err_uf;
  assign bus.err_ovf = r_err_ovf;
  assign bus.result  = (r_depth == '0) && (r_state != S_DEAD) && !r_err_ovf &&
                       !((r_state == S_EPEND) && r_uf_p && (STICKY_UF != 0));

endmodule

// File: tb/tb_token_nest_checker.sv
// Directed checks of token_nest_checker: sticky, non-sticky and 2-bit-depth
// instances all see the same character stream.
module tb_token_nest_checker;

  logic       clk;
  logic       rst_n;
  logic [7:0] tb_in;
  logic       tb_vld;
  int         n_checks;
  int         n_errors;

  token_nest_checker_if #(.DEPTH_W(8)) if_a ();
  token_nest_checker_if #(.DEPTH_W(8)) if_b ();
  token_nest_checker_if #(.DEPTH_W(2)) if_c ();

  assign if_a.in = tb_in;  assign if_a.in_valid = tb_vld;
  assign if_b.in = tb_in;  assign if_b.in_valid = tb_vld;
  assign if_c.in = tb_in;  assign if_c.in_valid = tb_vld;

  token_nest_checker #(.DEPTH_W(8), .STICKY_UF(1)) dut_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
  token_nest_checker #(.DEPTH_W(8), .STICKY_UF(0)) dut_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));
  token_nest_checker #(.DEPTH_W(2), .STICKY_UF(1)) dut_c (.clk(clk), .reset(rst_n), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    tb_in  = c;
    tb_vld = 1'b1;
    @(posedge clk);
    #1;
    tb_vld = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Non-consumed cycle carrying a byte that would derail the word if taken.
  task automatic gap();
    tb_in  = 8'h78;
    tb_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tb_vld = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    tb_in    = 8'h00;
    tb_vld   = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_result", 32'(if_a.result), 32'd1);
    check("rst_depth",  32'(if_a.depth),  32'd0);
    check("rst_err_uf", 32'(if_a.err_uf), 32'd0);
    check("rst_err_ovf",32'(if_a.err_ovf),32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mixed-case keywords
    send_str("BeGiN");
    check("mix_begin_depth",  32'(if_a.depth),  32'd1);
    check("mix_begin_result", 32'(if_a.result), 32'd0);
    send_str(" eNd");
    check("mix_end_depth",  32'(if_a.depth),  32'd0);
    check("mix_end_result", 32'(if_a.result), 32'd1);
    check("mix_end_err_uf", 32'(if_a.err_uf), 32'd0);
    send_char(8'h20);

    // Tentative begin reverted by trailing letter
    send_str("begin");
    check("begins_n_depth", 32'(if_a.depth), 32'd1);
    send_char("s");
    check("begins_s_depth",  32'(if_a.depth),  32'd0);
    check("begins_s_result", 32'(if_a.result), 32'd1);
    send_str(" end");
    check("ends_d_result", 32'(if_a.result), 32'd0);
    send_str("s ");
    check("ends_result", 32'(if_a.result), 32'd1);
    check("ends_err_uf", 32'(if_a.err_uf), 32'd0);

    // Invalid cycles must not be consumed
    send_str("be"); gap(); send_str("gin"); gap();
    check("gap_depth", 32'(if_a.depth), 32'd1);

    // Unmatched end: sticky vs non-sticky
    do_reset();
    send_str("end");
    check("uf_a_result_d", 32'(if_a.result), 32'd0);
    check("uf_b_result_d", 32'(if_b.result), 32'd1);
    send_char(8'h20);
    check("uf_a_err_uf",  32'(if_a.err_uf), 32'd1);
    check("uf_a_result",  32'(if_a.result), 32'd0);
    check("uf_b_err_uf",  32'(if_b.err_uf), 32'd1);
    check("uf_b_result",  32'(if_b.result), 32'd1);
    send_str("begin");
    check("dead_a_depth",  32'(if_a.depth),  32'd0);
    check("dead_a_result", 32'(if_a.result), 32'd0);
    check("nsticky_b_depth",  32'(if_b.depth),  32'd1);
    check("nsticky_b_result", 32'(if_b.result), 32'd0);

    // Reset out of DEAD
    #1 rst_n = 1'b0;
    #1;
    check("dead_rst_result", 32'(if_a.result), 32'd1);
    check("dead_rst_err_uf", 32'(if_a.err_uf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Overflow with 2-bit depth
    for (int k = 0; k < 3; k++) send_str("begin ");
    check("ovf_c_depth3",   32'(if_c.depth),   32'd3);
    check("ovf_c_pre_flag", 32'(if_c.err_ovf), 32'd0);
    send_str("begin");
    check("ovf_c_sat_depth", 32'(if_c.depth),   32'd3);
    check("ovf_c_pend_flag", 32'(if_c.err_ovf), 32'd0);
    send_char(8'h20);
    check("ovf_c_err_ovf", 32'(if_c.err_ovf), 32'd1);
    check("ovf_a_depth4",  32'(if_a.depth),   32'd4);
    check("ovf_a_err_ovf", 32'(if_a.err_ovf), 32'd0);
    for (int k = 0; k < 3; k++) send_str("end ");
    check("ovf_c_depth0",  32'(if_c.depth),  32'd0);
    check("ovf_c_result",  32'(if_c.result), 32'd0);
    check("ovf_a_depth1",  32'(if_a.depth),  32'd1);
    check("ovf_a_result",  32'(if_a.result), 32'd0);

    // Gapped partial word, reset mid-word, then a fresh unmatched end
    do_reset();
    send_char("b"); gap(); send_char("e"); gap(); send_char("g");
    check("gap_beg_depth",  32'(if_a.depth),  32'd0);
    check("gap_beg_result", 32'(if_a.result), 32'd1);
    tb_in  = 8'h65;
    tb_vld = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_depth",  32'(if_a.depth),  32'd0);
    check("mid_rst_result", 32'(if_a.result), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tb_vld = 1'b0;
    send_str("end");
    check("post_rst_d_result", 32'(if_a.result), 32'd0);
    send_char(8'h20);
    check("post_rst_err_uf", 32'(if_a.err_uf), 32'd1);
    send_str("begin end ");
    check("post_rst_locked", 32'(if_a.result), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/token_nest_checker.md
TOKEN_NEST_CHECKER -- requirements
Module: token_nest_checker

Interface
REQ-001 Parameter DEPTH_W, default 8: width of the nesting counter; maximum depth is 2^DEPTH_W-1.
REQ-002 Parameter STICKY_UF, default 1: 1 = an unmatched "end" locks result low until reset; 0 = an unmatched "end" is flagged and otherwise ignored.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset==0 immediately forces the reset state.
REQ-005 in  input  8  ASCII character.
REQ-006 in_valid  input  1  the character on `in` is consumed only on a clk edge where in_valid==1.
REQ-007 result  output  1  1 = the stream so far is balanced and error-free.
REQ-008 depth  output  DEPTH_W  current nesting depth, including a tentative count.
REQ-009 err_uf  output  1  sticky flag: an unmatched "end" was committed.
REQ-010 err_ovf  output  1  sticky flag: a "begin" arrived at maximum depth.

Function
REQ-011 Words are delimited only by space (8'h20); all other bytes are word characters.
REQ-012 A word is a keyword only if it is exactly "begin" or "end", case-insensitive per letter.
REQ-013 Cycles with in_valid==0 shall leave all state, flags and outputs unchanged.
REQ-014 The FSM shall use these states:
- IDLE (word start)
- B, BE, BEG, BEGI
- BPEND ("begin" matched, tentative)
- E, EN
- EPEND ("end" matched, tentative)
- SKIP (non-keyword word)
- DEAD
REQ-015 Transitions in IDLE:
- b/B -> B
- e/E -> E
- space -> IDLE
- any other byte -> SKIP
REQ-016 Transitions through a partial keyword:
- the expected next letter advances the state
- space -> IDLE
- any other byte -> SKIP
REQ-017 In SKIP, space -> IDLE; any other byte stays in SKIP.
REQ-018 BEGI + n/N -> BPEND:
- depth < max: depth increments in the same edge, tentatively
- depth == max: depth holds and internal flag ovf_p is set
REQ-019 EN + d/D -> EPEND:
- depth > 0: depth decrements in the same edge, tentatively
- depth == 0: depth holds and internal flag uf_p is set
REQ-020 BPEND/EPEND + space -> IDLE, which commits the keyword:
- ovf_p==1 sets err_ovf
- uf_p==1 with STICKY_UF=1 goes to DEAD instead of IDLE
- uf_p==1 with STICKY_UF=0 sets err_uf
REQ-021 BPEND/EPEND + any other byte -> SKIP:
- the tentative depth change is reverted in the same edge
- ovf_p and uf_p clear with no flag set
REQ-022 DEAD ignores all input until reset; in DEAD, err_uf==1.
REQ-023 result shall be driven combinationally from registers only.
REQ-024 result = (depth==0) AND NOT DEAD AND NOT err_ovf AND NOT (EPEND with uf_p AND STICKY_UF=1).
REQ-025 With STICKY_UF=0, err_uf shall not affect result.
REQ-026 Outputs reflect a consumed character from the clk edge that consumes it (latency 1 edge); the input-to-result path is not combinational.
REQ-027 Depth arithmetic is unsigned DEPTH_W bits; it shall never wrap past 0 or past 2^DEPTH_W-1.
REQ-028 End of stream needs no terminator: a pending keyword is already reflected in depth and result.

Reset
REQ-029 reset==0 shall asynchronously force:
- state=IDLE, depth=0
- err_uf=0, err_ovf=0, ovf_p=0, uf_p=0
- result=1
REQ-030 Reset asserted mid-word or in DEAD shall discard all history; the first valid byte after release is treated as the start of a word.
REQ-031 Release of reset is sampled synchronously; no character is consumed on the edge where reset==0.

Verification
REQ-032 "BeGiN eNd", all valid, STICKY_UF=1:
- depth 1 after 'N'; result 0
- depth 0 after 'd'; result 1
- err_uf=0
REQ-033 "begins":
- depth 1 after 'n'
- depth 0 after 's'; state SKIP; result 1
REQ-034 "end begin", STICKY_UF=1:
- result 0 after 'd'; DEAD after the following space
- result stays 0 through "begin"
- err_uf=1
REQ-035 Same stream, STICKY_UF=0:
- err_uf=1 after the space
- depth 1 after "begin"; result 0
REQ-036 DEPTH_W=2, "begin " x4:
- depth saturates at 3; err_ovf=1 after the fourth space
- result 0 even after three "end "
REQ-037 "beg" with in_valid toggling 1,0,1,0,1, then reset low mid-word, then "end":
- gap cycles leave state unchanged
- after reset: depth 0, result 1
- "end" then drives result 0 and locks (DEAD) on the next space
